// File: rtl/buyruk_onbellek_denetleyici_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache controller.
// Latency: none, wires only.
// Backpressure: durdur_o stalls fetch; refill completes on getir_asamasina_veri_hazir_i.
interface buyruk_onbellek_denetleyici_if;
   logic [31:0]  getir_adres_i;
   logic         getir_istek_i;
   logic         gecersiz_kil_i;
   logic [31:0]  buyruk_o;
   logic         buyruk_gecerli_o;
   logic         durdur_o;
   logic [31:0]  bbellek_adres_o;
   logic         bbellek_istek_o;
   logic         bbellek_oku_o;
   logic [127:0] okunan_veri_obegi_i;
   logic         getir_asamasina_veri_hazir_i;

   // Controller side
   modport slave (
      input  getir_adres_i, getir_istek_i, gecersiz_kil_i,
      input  okunan_veri_obegi_i, getir_asamasina_veri_hazir_i,
      output buyruk_o, buyruk_gecerli_o, durdur_o,
      output bbellek_adres_o, bbellek_istek_o, bbellek_oku_o
   );

   // Fetch stage / memory wrapper side
   modport master (
      output getir_adres_i, getir_istek_i, gecersiz_kil_i,
      output okunan_veri_obegi_i, getir_asamasina_veri_hazir_i,
      input  buyruk_o, buyruk_gecerli_o, durdur_o,
      input  bbellek_adres_o, bbellek_istek_o, bbellek_oku_o
   );
endinterface

// File: rtl/buyruk_onbellek_denetleyici.sv
// Direct-mapped instruction cache, 16-byte lines; BUYRUK_ONBELLEK_SAYAC_EN adds hit/miss counters.
// Latency: hit 1 cycle; miss = wrapper latency + 1 cycle.
// Backpressure: durdur_o (combinational) held high from the miss cycle until refill completes.
module buyruk_onbellek_denetleyici #(
   parameter int SATIR_SAYISI = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   buyruk_onbellek_denetleyici_if.slave bus_if
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
   ,
   output logic [31:0] isabet_sayisi_o,
   output logic [31:0] iska_sayisi_o
`endif
);
   localparam int IW = $clog2(SATIR_SAYISI);
   localparam int TW = 28 - IW;

   typedef enum logic {BOSTA, BEKLE} durum_t;

   durum_t                  durum_q, durum_d;
   logic [SATIR_SAYISI-1:0] gecerli_q;
   logic [TW-1:0]           etiket_q [SATIR_SAYISI];
   logic [127:0]            veri_q   [SATIR_SAYISI];
   logic [31:0]             buyruk_q;
   logic                    buyruk_gecerli_q;
   logic [27:0]             satir_adres_q;
   logic [1:0]              kelime_q;
   logic                    bekleyen_kil_q;

   logic [IW-1:0]           getir_indis;
   logic [TW-1:0]           getir_etiket;
   logic [IW-1:0]           dolum_indis;
   logic [TW-1:0]           dolum_etiket;
   logic [127:0]            isabet_satiri;
   logic                    isabet;
   logic                    durdur;
   logic                    bb_istek;
   logic                    unused_adres_bitleri;

   assign getir_indis   = bus_if.getir_adres_i[4 +: IW];
   assign getir_etiket  = bus_if.getir_adres_i[31 -: TW];
   assign dolum_indis   = satir_adres_q[0 +: IW];
   assign dolum_etiket  = satir_adres_q[27 -: TW];
   assign isabet_satiri = veri_q[getir_indis];
   // A flush in the same cycle as a request forces that request to miss.
   assign isabet = gecerli_q[getir_indis] && (etiket_q[getir_indis] == getir_etiket)
                   && !bus_if.gecersiz_kil_i;
   assign unused_adres_bitleri = ^bus_if.getir_adres_i[1:0];

   // Next state and the combinational stall / refill request.
   always_comb begin
      durum_d  = durum_q;
      durdur   = 1'b0;
      bb_istek = 1'b0;
      case (durum_q)
         BOSTA: begin
            if (bus_if.getir_istek_i && !isabet) begin
               durdur  = 1'b1;
               durum_d = BEKLE;
            end
         end
         BEKLE: begin
            durdur   = 1'b1;
            // Held until completion, dropped in the completion cycle so the wrapper does not restart.
            bb_istek = !bus_if.getir_asamasina_veri_hazir_i;
            if (bus_if.getir_asamasina_veri_hazir_i) durum_d = BOSTA;
         end
         default: durum_d = BOSTA;
      endcase
   end

   // State, valid bits, delivered instruction, latched miss address and pending flush.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         durum_q          <= BOSTA;
         gecerli_q        <= '0;
         buyruk_q         <= '0;
         buyruk_gecerli_q <= 1'b0;
         satir_adres_q    <= '0;
         kelime_q         <= '0;
         bekleyen_kil_q   <= 1'b0;
      end else begin
         durum_q          <= durum_d;
         buyruk_gecerli_q <= 1'b0;
         if (durum_q == BOSTA) begin
            if (bus_if.getir_istek_i && isabet) begin
               buyruk_q         <= isabet_satiri[{bus_if.getir_adres_i[3:2], 5'b0} +: 32];
               buyruk_gecerli_q <= 1'b1;
            end else if (bus_if.getir_istek_i) begin
               satir_adres_q <= bus_if.getir_adres_i[31:4];
               kelime_q      <= bus_if.getir_adres_i[3:2];
            end
            if (bus_if.gecersiz_kil_i) gecerli_q <= '0;
         end else begin
            if (bus_if.gecersiz_kil_i) bekleyen_kil_q <= 1'b1;
            if (bus_if.getir_asamasina_veri_hazir_i) begin
               buyruk_q         <= bus_if.okunan_veri_obegi_i[{kelime_q, 5'b0} +: 32];
               buyruk_gecerli_q <= 1'b1;
               // A flush seen during the refill leaves the new line invalid too.
               if (bekleyen_kil_q || bus_if.gecersiz_kil_i) begin
                  gecerli_q      <= '0;
                  bekleyen_kil_q <= 1'b0;
               end else begin
                  gecerli_q[dolum_indis] <= 1'b1;
               end
            end
         end
      end
   end

   // Line data and tag install; gated by reset so an abandoned refill writes nothing.
   always_ff @(posedge clk_i) begin
      if (rst_i && (durum_q == BEKLE) && bus_if.getir_asamasina_veri_hazir_i) begin
         veri_q[dolum_indis]   <= bus_if.okunan_veri_obegi_i;
         etiket_q[dolum_indis] <= dolum_etiket;
      end
   end

`ifdef BUYRUK_ONBELLEK_SAYAC_EN
   logic [31:0] isabet_sayisi_q;
   logic [31:0] iska_sayisi_q;

   // Hit and miss event counters, wrapping naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         isabet_sayisi_q <= '0;
         iska_sayisi_q   <= '0;
      end else if (durum_q == BOSTA) begin
         if (bus_if.getir_istek_i && isabet) isabet_sayisi_q <= isabet_sayisi_q + 32'd1;
         if (durum_d == BEKLE)               iska_sayisi_q   <= iska_sayisi_q + 32'd1;
      end
   end

   assign isabet_sayisi_o = isabet_sayisi_q;
   assign iska_sayisi_o   = iska_sayisi_q;
`endif

   assign bus_if.buyruk_o         = buyruk_q;
   assign bus_if.buyruk_gecerli_o = buyruk_gecerli_q;
   assign bus_if.durdur_o         = durdur;
   assign bus_if.bbellek_adres_o  = {satir_adres_q, 4'b0000};
   assign bus_if.bbellek_istek_o  = bb_istek;
   assign bus_if.bbellek_oku_o    = bb_istek;
endmodule

// File: tb/tb_buyruk_onbellek_denetleyici.sv
// Bench for the instruction cache controller: directed fetches against a line-content model.
// Latency: expected instructions queued at fetch time and matched when buyruk_gecerli_o pulses.
// Backpressure: bench acts as fetch stage and memory wrapper with per-refill completion delay.
module tb_buyruk_onbellek_denetleyici;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   toplam = 0;
   int   hatali = 0;
   int   refill_sayisi = 0;
   int   beklenen_refill = 0;
   logic onceki_istek = 1'b0;
   logic [31:0] bekl_q [$];

   buyruk_onbellek_denetleyici_if bus ();

`ifdef BUYRUK_ONBELLEK_SAYAC_EN
   logic [31:0] isabet_sayisi;
   logic [31:0] iska_sayisi;
`endif

   buyruk_onbellek_denetleyici #(.SATIR_SAYISI(64)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_if (bus)
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
      ,
      .isabet_sayisi_o (isabet_sayisi),
      .iska_sayisi_o   (iska_sayisi)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      toplam++;
      assert (gozlenen === beklenen) else begin
         hatali++;
         $error("FAIL %s: observed=%h expected=%h", etiket, gozlenen, beklenen);
      end
   endtask

   // Memory contents model: each word encodes its own address.
   function automatic logic [31:0] kelime(input logic [31:0] a);
      return {16'hC0DE, a[15:2], 2'b00};
   endfunction

   function automatic logic [127:0] satir(input logic [31:0] a);
      logic [31:0] t;
      t = {a[31:4], 4'b0000};
      return {kelime(t + 32'd12), kelime(t + 32'd8), kelime(t + 32'd4), kelime(t)};
   endfunction

   // Scoreboard: every delivered instruction must match the oldest expected one.
   always @(negedge clk) begin
      if (bus.buyruk_gecerli_o === 1'b1) begin
         if (bekl_q.size() == 0) kontrol("unexpected_delivery", bus.buyruk_o, 32'hxxxx_xxxx);
         else kontrol("buyruk", bus.buyruk_o, bekl_q.pop_front());
      end
      if (bus.bbellek_istek_o === 1'b1 && !onceki_istek) refill_sayisi++;
      onceki_istek = (bus.bbellek_istek_o === 1'b1);
   end

   // One fetch; a miss is served by the wrapper after gecikme request cycles.
   task automatic getir(input logic [31:0] a, input bit iska, input int gecikme, input bit kil);
      bekl_q.push_back(kelime(a));
      bus.getir_adres_i = a;
      bus.getir_istek_i = 1'b1;
      @(negedge clk);
      kontrol("durdur_on_request", {31'd0, bus.durdur_o}, {31'd0, iska});
      if (iska) begin
         beklenen_refill++;
         @(posedge clk); #1;
         bus.gecersiz_kil_i = 1'b0;
         for (int i = 0; i < gecikme; i++) begin
            if (kil && i == 0) bus.gecersiz_kil_i = 1'b1;
            @(negedge clk);
            kontrol("istek_held", {31'd0, bus.bbellek_istek_o}, 32'd1);
            kontrol("oku_held", {31'd0, bus.bbellek_oku_o}, 32'd1);
            kontrol("durdur_held", {31'd0, bus.durdur_o}, 32'd1);
            kontrol("refill_adres", bus.bbellek_adres_o, {a[31:4], 4'b0000});
            @(posedge clk); #1;
            bus.gecersiz_kil_i = 1'b0;
         end
         bus.getir_asamasina_veri_hazir_i = 1'b1;
         bus.okunan_veri_obegi_i = satir(a);
         @(negedge clk);
         kontrol("istek_low_on_hazir", {31'd0, bus.bbellek_istek_o}, 32'd0);
         kontrol("durdur_on_hazir", {31'd0, bus.durdur_o}, 32'd1);
         @(posedge clk); #1;
         bus.getir_asamasina_veri_hazir_i = 1'b0;
         bus.okunan_veri_obegi_i = '0;
         bus.getir_istek_i = 1'b0;
      end else begin
         @(posedge clk); #1;
         bus.gecersiz_kil_i = 1'b0;
         bus.getir_istek_i = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] akis [3];
      akis[0] = 32'h0000_0100;
      akis[1] = 32'h0000_0104;
      akis[2] = 32'h0000_010C;
      bus.getir_adres_i = '0;
      bus.getir_istek_i = 1'b0;
      bus.gecersiz_kil_i = 1'b0;
      bus.okunan_veri_obegi_i = '0;
      bus.getir_asamasina_veri_hazir_i = 1'b0;

      // Reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      kontrol("reset_buyruk", bus.buyruk_o, 32'd0);
      kontrol("reset_gecerli", {31'd0, bus.buyruk_gecerli_o}, 32'd0);
      kontrol("reset_adres", bus.bbellek_adres_o, 32'd0);
      kontrol("reset_istek", {31'd0, bus.bbellek_istek_o}, 32'd0);
      kontrol("reset_durdur", {31'd0, bus.durdur_o}, 32'd0);
      @(posedge clk); #1;

      // Cold miss, word 2 of line 0x100
      getir(32'h0000_0108, 1'b1, 10, 1'b0);
      kontrol("cold_refill_count", refill_sayisi, 32'd1);

      // Hit stream, one instruction per cycle
      for (int k = 0; k < 3; k++) begin
         bekl_q.push_back(kelime(akis[k]));
         bus.getir_adres_i = akis[k];
         bus.getir_istek_i = 1'b1;
         @(negedge clk);
         kontrol("stream_durdur", {31'd0, bus.durdur_o}, 32'd0);
         kontrol("stream_istek", {31'd0, bus.bbellek_istek_o}, 32'd0);
         if (k > 0) kontrol("stream_back_to_back", {31'd0, bus.buyruk_gecerli_o}, 32'd1);
         @(posedge clk); #1;
      end
      bus.getir_istek_i = 1'b0;
      @(negedge clk);
      kontrol("stream_last", {31'd0, bus.buyruk_gecerli_o}, 32'd1);
      @(posedge clk); #1;
      kontrol("stream_no_refill", refill_sayisi, 32'd1);

      // Conflict eviction on index 0x10
      getir(32'h0000_0500, 1'b1, 3, 1'b0);
      getir(32'h0000_0100, 1'b1, 2, 1'b0);

      // Long arbitration delay
      getir(32'h0000_0240, 1'b1, 40, 1'b0);
      getir(32'h0000_0244, 1'b0, 0, 1'b0);

      // Flush while idle, then flush together with a request
      bus.gecersiz_kil_i = 1'b1;
      @(posedge clk); #1;
      bus.gecersiz_kil_i = 1'b0;
      getir(32'h0000_0104, 1'b1, 2, 1'b0);
      getir(32'h0000_0104, 1'b0, 0, 1'b0);
      bus.gecersiz_kil_i = 1'b1;
      getir(32'h0000_0104, 1'b1, 2, 1'b0);

      // Flush during a refill: delivered but not retained, other lines dropped as well
      getir(32'h0000_0300, 1'b1, 5, 1'b1);
      getir(32'h0000_0104, 1'b1, 2, 1'b0);
      getir(32'h0000_0300, 1'b1, 2, 1'b0);
      getir(32'h0000_0308, 1'b0, 0, 1'b0);

      // Reset in the middle of a refill, then a stale completion
      bus.getir_adres_i = 32'h0000_0400;
      bus.getir_istek_i = 1'b1;
      @(negedge clk);
      kontrol("rst_test_miss", {31'd0, bus.durdur_o}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      kontrol("rst_test_istek", {31'd0, bus.bbellek_istek_o}, 32'd1);
      beklenen_refill++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.getir_istek_i = 1'b0;
      @(negedge clk);
      kontrol("rst_mid_durdur", {31'd0, bus.durdur_o}, 32'd0);
      kontrol("rst_mid_istek", {31'd0, bus.bbellek_istek_o}, 32'd0);
      kontrol("rst_mid_gecerli", {31'd0, bus.buyruk_gecerli_o}, 32'd0);
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
      kontrol("rst_isabet_sayisi", isabet_sayisi, 32'd0);
      kontrol("rst_iska_sayisi", iska_sayisi, 32'd0);
`endif
      @(posedge clk); #1;
      bus.getir_asamasina_veri_hazir_i = 1'b1;
      bus.okunan_veri_obegi_i = satir(32'h0000_0400);
      @(negedge clk);
      kontrol("stale_hazir_istek", {31'd0, bus.bbellek_istek_o}, 32'd0);
      kontrol("stale_hazir_durdur", {31'd0, bus.durdur_o}, 32'd0);
      @(posedge clk); #1;
      bus.getir_asamasina_veri_hazir_i = 1'b0;
      bus.okunan_veri_obegi_i = '0;
      @(negedge clk);
      kontrol("stale_no_delivery", {31'd0, bus.buyruk_gecerli_o}, 32'd0);
      @(posedge clk); #1;
      getir(32'h0000_0400, 1'b1, 2, 1'b0);
      getir(32'h0000_0404, 1'b0, 0, 1'b0);
`ifdef BUYRUK_ONBELLEK_SAYAC_EN
      kontrol("isabet_sayisi", isabet_sayisi, 32'd1);
      kontrol("iska_sayisi", iska_sayisi, 32'd1);
`endif

      repeat (3) @(posedge clk);
      #1;
      kontrol("scoreboard_empty", bekl_q.size(), 32'd0);
      kontrol("refill_total", refill_sayisi, beklenen_refill);
      $display("test done: total=%0d bad=%0d", toplam, hatali);
      $finish;
   end
endmodule
